// File: rtl/ntt_coeff_loader.sv
// Purpose : gathers a serial coefficient stream, reduces each word mod MODULUS, packs the
//           frame into the flat NTT data_in bus, pulses ntt_start, then holds until ntt_done.
// Latency : last word accepted at edge t -> ntt_start high for exactly the cycle after t.
// Backpressure: s_ready is high only while loading; it drops through FIRE and WAIT and
//           returns the cycle after the rising edge of ntt_done.
//
// Ports
//   clk, rst           single rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready    coefficient handshake; s_data raw word, s_last ends a frame
//   ntt_start          one-cycle start pulse to the NTT
//   ntt_done           NTT completion level; only its rising edge releases the loader
//   ntt_data_in        packed frame, slot i = bus[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   busy               high while a frame is firing or waiting on the NTT
//   err_len            pulses with ntt_start when the frame length was not N

module ntt_coeff_loader #(
    parameter int N          = 512,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int MODULUS    = 7681
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_last,
    output logic                      ntt_start,
    input  logic                      ntt_done,
    output logic [N*DATA_WIDTH-1:0]   ntt_data_in,
    output logic                      busy,
    output logic                      err_len
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] LP_MOD     = DATA_WIDTH'(MODULUS);
    localparam logic [ADDR_WIDTH-1:0] LP_IDX_MAX = ADDR_WIDTH'(N - 1);

    state_t                    r_state;
    state_t                    w_next;
    logic [ADDR_WIDTH-1:0]     r_idx;
    logic [N*DATA_WIDTH-1:0]   r_bus;
    logic                      r_done_q;
    logic                      r_len_bad;

    logic                      w_s_ready;
    logic                      w_start;
    logic                      w_busy;
    logic                      w_err_len;
    logic                      w_accept;
    logic                      w_idx_max;
    logic                      w_frame_end;
    logic                      w_done_edge;
    logic [DATA_WIDTH-1:0]     w_mod;

    // Both operands are DATA_WIDTH wide, so the remainder is exact for every input word.
    assign w_mod       = s_data % LP_MOD;
    assign w_accept    = s_valid & w_s_ready;
    assign w_idx_max   = (r_idx == LP_IDX_MAX);
    // A full slot count fires the frame even without s_last, so idx can never wrap.
    assign w_frame_end = w_idx_max | s_last;
    // done_q follows ntt_done in every state, so a level already high on entry to
    // WAIT does not look like an edge.
    assign w_done_edge = ntt_done & ~r_done_q;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept && w_frame_end) begin
                    w_next = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done_edge) begin
                    w_next = ST_LOAD;
                end
            end
            default: begin
                w_next = ST_LOAD;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        w_s_ready = 1'b0;
        w_start   = 1'b0;
        w_busy    = 1'b1;
        w_err_len = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_s_ready = 1'b1;
                w_busy    = 1'b0;
            end
            ST_FIRE: begin
                w_start   = 1'b1;
                w_err_len = r_len_bad;
            end
            ST_WAIT: begin
                w_busy    = 1'b1;
            end
            default: begin
                w_busy    = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus     <= '0;
            r_idx     <= '0;
            r_done_q  <= 1'b0;
            r_len_bad <= 1'b0;
        end else begin
            r_done_q <= ntt_done;
            if (w_accept) begin
                r_bus[r_idx*DATA_WIDTH +: DATA_WIDTH] <= w_mod;
                if (w_frame_end) begin
                    // Exact only when the last marker lands on the final slot; a short
                    // frame (s_last early) or a long one (full without s_last) is flagged.
                    r_len_bad <= ~(w_idx_max & s_last);
                end else begin
                    r_idx <= r_idx + ADDR_WIDTH'(1);
                end
            end else if ((r_state == ST_WAIT) && w_done_edge) begin
                // Clearing here is what zero-pads the tail of the next short frame.
                r_bus <= '0;
                r_idx <= '0;
            end
        end
    end

    assign s_ready     = w_s_ready;
    assign ntt_start   = w_start;
    assign busy        = w_busy;
    assign err_len     = w_err_len;
    assign ntt_data_in = r_bus;

endmodule
